// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall merge, exception redirect and flush sequencing for the
// five-stage core. Optional stall watchdog enabled by CTRL_STALL_WATCHDOG_EN;
// without it stall_timeout is tied low and no counter is built.
module pipeline_ctrl #(
    parameter int          STAGES    = 6,
    parameter int          NUM_REQ   = 2,
    parameter int          FLUSH_LEN = 1,
    parameter logic [31:0] EXC_VEC   = 32'hbfc00380,
    parameter logic [31:0] UNK_VEC   = 32'h00000000,
    parameter int          STALL_MAX = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] stallreq_i,
    input  logic [31:0]        excepttype_i,
    input  logic [31:0]        cp0_epc_i,
    output logic [STAGES-1:0]  stall,
    output logic               flush,
    output logic [31:0]        new_pc,
    output logic               redirect,
    output logic               exc_unknown,
    output logic               stall_timeout
);

    if (NUM_REQ > STAGES - 2 || FLUSH_LEN < 1 || STALL_MAX < 1) begin : g_param_check
        $error("pipeline_ctrl: illegal parameter combination");
    end

    typedef enum logic {IDLE, FLUSH} state_t;

    // Counter only has to hold FLUSH_LEN-1 trailing cycles; keep at least one bit.
    localparam int                FCNT_W    = (FLUSH_LEN > 2) ? $clog2(FLUSH_LEN) : 1;
    localparam logic [FCNT_W-1:0] FCNT_INIT = FCNT_W'(FLUSH_LEN - 1);
    localparam logic [FCNT_W-1:0] FCNT_ONE  = FCNT_W'(1);

    state_t              state_q, state_d;
    logic [FCNT_W-1:0]   cnt_q, cnt_d;
    logic [STAGES-1:0]   merged;
    logic                req_any;
    int                  req_top;

    // Exception codes that vector to the general handler.
    function automatic logic code_to_exc_vec(input logic [31:0] code);
        case (code)
            32'h1, 32'h2, 32'h4, 32'h5,
            32'h8, 32'ha, 32'hc, 32'hd: return 1'b1;
            default:                    return 1'b0;
        endcase
    endfunction

    // Highest requesting stage holds itself and every stage upstream of it.
    always_comb begin
        req_any = 1'b0;
        req_top = 0;
        merged  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (stallreq_i[k]) begin
                req_any = 1'b1;
                req_top = k + 2;
            end
        end
        for (int j = 0; j < STAGES; j++) begin
            if (req_any && j <= req_top) merged[j] = 1'b1;
        end
    end

    // Next-state and outputs; reset forces every output low and returns to IDLE.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stall       = '0;
        flush       = 1'b0;
        redirect    = 1'b0;
        new_pc      = '0;
        exc_unknown = 1'b0;
        if (rst) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (excepttype_i != 32'h0) begin
                        flush    = 1'b1;
                        redirect = 1'b1;
                        if (code_to_exc_vec(excepttype_i)) begin
                            new_pc = EXC_VEC;
                        end else if (excepttype_i == 32'he) begin
                            new_pc = cp0_epc_i;
                        end else begin
                            new_pc      = UNK_VEC;
                            exc_unknown = 1'b1;
                        end
                        if (FLUSH_LEN > 1) begin
                            state_d = FLUSH;
                            cnt_d   = FCNT_INIT;
                        end
                    end else begin
                        stall = merged;
                    end
                end
                FLUSH: begin
                    // Exceptions seen here belong to instructions being flushed.
                    flush = 1'b1;
                    if (cnt_q == FCNT_ONE) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - FCNT_ONE;
                    end
                end
            endcase
        end
    end

    // FSM and flush counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef CTRL_STALL_WATCHDOG_EN
    localparam int               WD_W   = $clog2(STALL_MAX + 1);
    localparam logic [WD_W-1:0]  WD_MAX = WD_W'(STALL_MAX);

    logic [WD_W-1:0] wd_cnt_q;
    logic            wd_tmo_q;

    function automatic logic [WD_W-1:0] sat_inc(input logic [WD_W-1:0] v);
        return (v == WD_MAX) ? v : v + WD_W'(1);
    endfunction

    // Count consecutive stalled cycles; the timeout flag is sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_q <= '0;
            wd_tmo_q <= 1'b0;
        end else if (stall != '0) begin
            wd_cnt_q <= sat_inc(wd_cnt_q);
            if (sat_inc(wd_cnt_q) == WD_MAX) wd_tmo_q <= 1'b1;
        end else begin
            wd_cnt_q <= '0;
        end
    end

    assign stall_timeout = wd_tmo_q & ~rst;
`else
    assign stall_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: three pipeline_ctrl instances (defaults, FLUSH_LEN=3 with a
// nonzero UNK_VEC, STALL_MAX=4) share one stimulus stream and are compared
// against a cycle-level behavioural model of the control rules.
module tb_pipeline_ctrl;

`ifdef CTRL_STALL_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    localparam int          FL_LEN [3] = '{1, 3, 1};
    localparam int          SMAX   [3] = '{255, 255, 4};
    localparam logic [31:0] UNKV   [3] = '{32'h0, 32'h8000_0180, 32'h0};
    localparam logic [31:0] EXC_V      = 32'hbfc00380;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [31:0] exc = 32'h0;
    logic [31:0] epc = 32'h0;

    logic [5:0]  st  [3];
    logic        fl  [3];
    logic [31:0] pc  [3];
    logic        rd  [3];
    logic        unk [3];
    logic        to  [3];

    int checks = 0;
    int errors = 0;

    // Model state: remaining trailing flush cycles, consecutive stall run, sticky timeout.
    int left [3] = '{default: 0};
    int run  [3] = '{default: 0};
    bit tmo  [3] = '{default: 1'b0};

    always #5 clk = ~clk;

    pipeline_ctrl u_dflt (
        .clk(clk), .rst(rst), .stallreq_i(req), .excepttype_i(exc), .cp0_epc_i(epc),
        .stall(st[0]), .flush(fl[0]), .new_pc(pc[0]), .redirect(rd[0]),
        .exc_unknown(unk[0]), .stall_timeout(to[0])
    );

    pipeline_ctrl #(.FLUSH_LEN(3), .UNK_VEC(32'h8000_0180)) u_fl3 (
        .clk(clk), .rst(rst), .stallreq_i(req), .excepttype_i(exc), .cp0_epc_i(epc),
        .stall(st[1]), .flush(fl[1]), .new_pc(pc[1]), .redirect(rd[1]),
        .exc_unknown(unk[1]), .stall_timeout(to[1])
    );

    pipeline_ctrl #(.STALL_MAX(4)) u_wd (
        .clk(clk), .rst(rst), .stallreq_i(req), .excepttype_i(exc), .cp0_epc_i(epc),
        .stall(st[2]), .flush(fl[2]), .new_pc(pc[2]), .redirect(rd[2]),
        .exc_unknown(unk[2]), .stall_timeout(to[2])
    );

    // Expected {stall, flush, redirect, exc_unknown, stall_timeout, new_pc} for instance i.
    function automatic logic [41:0] model_out(input int i);
        logic [5:0]  s;
        logic [31:0] p;
        logic        f, r, u, t;
        int          top;
        s = '0; p = '0; f = 1'b0; r = 1'b0; u = 1'b0; t = 1'b0;
        if (!rst) begin
            t = tmo[i];
            if (left[i] > 0) begin
                f = 1'b1;
            end else if (exc != 32'h0) begin
                f = 1'b1;
                r = 1'b1;
                case (exc)
                    32'h1, 32'h2, 32'h4, 32'h5, 32'h8, 32'ha, 32'hc, 32'hd: p = EXC_V;
                    32'he:   p = epc;
                    default: begin p = UNKV[i]; u = 1'b1; end
                endcase
            end else begin
                top = -1;
                for (int k = 0; k < 2; k++) if (req[k]) top = k;
                if (top >= 0) s = 6'((1 << (top + 3)) - 1);
            end
        end
        return {s, f, r, u, t, p};
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                left[i] <= 0;
                run[i]  <= 0;
                tmo[i]  <= 1'b0;
            end else begin
                if (left[i] > 0)        left[i] <= left[i] - 1;
                else if (exc != 32'h0)  left[i] <= FL_LEN[i] - 1;
                if ((model_out(i) >> 36) != 42'd0) begin
                    run[i] <= (run[i] + 1 > SMAX[i]) ? SMAX[i] : run[i] + 1;
                    if (WD && run[i] + 1 >= SMAX[i]) tmo[i] <= 1'b1;
                end else begin
                    run[i] <= 0;
                end
            end
        end
    end

    task automatic step(input logic r, input logic [1:0] q, input logic [31:0] e, input logic [31:0] p);
        @(negedge clk);
        rst = r; req = q; exc = e; epc = p;
        #2;
    endtask

    task automatic test_reset();
        step(1'b1, 2'b11, 32'h1, 32'h1234_5678);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({st[i], fl[i], rd[i], unk[i], to[i], pc[i]} !== 42'd0) begin
                errors++;
                $display("FAIL reset_active inst%0d got st=%b fl=%b rd=%b unk=%b to=%b pc=%h, want all 0",
                         i, st[i], fl[i], rd[i], unk[i], to[i], pc[i]);
            end
        end
        step(1'b0, 2'b00, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({st[i], fl[i], rd[i], unk[i], to[i], pc[i]} !== 42'd0) begin
                errors++;
                $display("FAIL reset_idle inst%0d got st=%b fl=%b rd=%b unk=%b to=%b pc=%h, want all 0",
                         i, st[i], fl[i], rd[i], unk[i], to[i], pc[i]);
            end
        end
    endtask

    task automatic test_stall_merge();
        logic [1:0] pat  [3] = '{2'b01, 2'b10, 2'b11};
        logic [5:0] want [3] = '{6'b000111, 6'b001111, 6'b001111};
        for (int n = 0; n < 3; n++) begin
            step(1'b0, pat[n], 32'h0, 32'h0);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (st[i] !== want[n] || fl[i] !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_merge req=%b inst%0d got stall=%b flush=%b, want stall=%b flush=0",
                             pat[n], i, st[i], fl[i], want[n]);
                end
            end
        end
        step(1'b0, 2'b00, 32'h0, 32'h0);
        checks++;
        if (st[0] !== 6'b0) begin
            errors++;
            $display("FAIL stall_none got %b want 000000", st[0]);
        end
    endtask

    task automatic test_exception_decode();
        logic [31:0] code [3] = '{32'h8, 32'he, 32'h7};
        logic [31:0] want [3] = '{32'hbfc00380, 32'h80001234, 32'h0};
        logic        wunk [3] = '{1'b0, 1'b0, 1'b1};
        for (int n = 0; n < 3; n++) begin
            step(1'b0, 2'b00, code[n], 32'h80001234);
            checks++;
            if (pc[0] !== want[n] || fl[0] !== 1'b1 || rd[0] !== 1'b1 || unk[0] !== wunk[n]) begin
                errors++;
                $display("FAIL decode code=%h got pc=%h fl=%b rd=%b unk=%b, want pc=%h fl=1 rd=1 unk=%b",
                         code[n], pc[0], fl[0], rd[0], unk[0], want[n], wunk[n]);
            end
            step(1'b0, 2'b00, 32'h0, 32'h80001234);
            checks++;
            if (fl[0] !== 1'b0 || rd[0] !== 1'b0 || pc[0] !== 32'h0) begin
                errors++;
                $display("FAIL decode_after code=%h got fl=%b rd=%b pc=%h, want 0 0 0",
                         code[n], fl[0], rd[0], pc[0]);
            end
            step(1'b0, 2'b00, 32'h0, 32'h0);
            step(1'b0, 2'b00, 32'h0, 32'h0);
        end
    endtask

    task automatic test_simultaneous();
        // {stall, flush, redirect, new_pc} seen on the FLUSH_LEN=3 instance.
        logic [1:0]  q   [7] = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        logic [31:0] e   [7] = '{32'hc, 32'h1, 32'h0, 32'h0, 32'hc, 32'h0, 32'h0};
        logic        r   [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [39:0] want[7] = '{{6'b0, 1'b1, 1'b1, EXC_V}, {6'b0, 1'b1, 1'b0, 32'h0},
                                 {6'b0, 1'b1, 1'b0, 32'h0}, {6'b0, 1'b0, 1'b0, 32'h0},
                                 {6'b0, 1'b1, 1'b1, EXC_V}, {6'b0, 1'b0, 1'b0, 32'h0},
                                 {6'b0, 1'b0, 1'b0, 32'h0}};
        step(1'b0, 2'b00, 32'h0, 32'h0);
        step(1'b0, 2'b00, 32'h0, 32'h0);
        step(1'b0, 2'b00, 32'h0, 32'h0);
        for (int n = 0; n < 7; n++) begin
            step(r[n], q[n], e[n], 32'h0);
            checks++;
            if ({st[1], fl[1], rd[1], pc[1]} !== want[n]) begin
                errors++;
                $display("FAIL simultaneous cycle%0d got st=%b fl=%b rd=%b pc=%h, want %h",
                         n, st[1], fl[1], rd[1], pc[1], want[n]);
            end
            if (n == 0) begin
                checks++;
                if (st[0] !== 6'b0 || fl[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL exc_beats_stall got st=%b fl=%b, want 000000 1", st[0], fl[0]);
                end
            end
        end
        step(1'b1, 2'b00, 32'h4, 32'h0);
        step(1'b0, 2'b00, 32'h4, 32'h0);
        checks++;
        if (fl[1] !== 1'b1 || rd[1] !== 1'b1 || pc[1] !== EXC_V) begin
            errors++;
            $display("FAIL exc_after_reset got fl=%b rd=%b pc=%h, want 1 1 %h", fl[1], rd[1], pc[1], EXC_V);
        end
        for (int n = 0; n < 3; n++) step(1'b0, 2'b00, 32'h0, 32'h0);
    endtask

    task automatic test_watchdog();
        logic [1:0] q [10] = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00};
        logic       w [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, WD, WD};
        step(1'b1, 2'b00, 32'h0, 32'h0);
        for (int n = 0; n < 10; n++) begin
            step(1'b0, q[n], 32'h0, 32'h0);
            checks++;
            if (to[2] !== w[n]) begin
                errors++;
                $display("FAIL watchdog cycle%0d got stall_timeout=%b want %b", n, to[2], w[n]);
            end
        end
        checks++;
        if (to[0] !== 1'b0 || to[1] !== 1'b0) begin
            errors++;
            $display("FAIL watchdog_long got %b %b want 0 0", to[0], to[1]);
        end
        step(1'b1, 2'b00, 32'h0, 32'h0);
        step(1'b0, 2'b00, 32'h0, 32'h0);
        checks++;
        if (to[2] !== 1'b0) begin
            errors++;
            $display("FAIL watchdog_clear got %b want 0", to[2]);
        end
    endtask

    task automatic test_random();
        logic [31:0] codes [14] = '{32'h1, 32'h2, 32'h4, 32'h5, 32'h8, 32'ha, 32'hc, 32'hd,
                                    32'he, 32'h3, 32'h7, 32'h9, 32'h20, 32'hffff_ffff};
        logic [31:0] e;
        logic [41:0] exp_v;
        for (int n = 0; n < 400; n++) begin
            e = ($urandom_range(0, 9) < 6) ? 32'h0 : codes[$urandom_range(0, 13)];
            step($urandom_range(0, 39) == 0, 2'($urandom), e, $urandom);
            for (int i = 0; i < 3; i++) begin
                exp_v = model_out(i);
                checks++;
                if ({st[i], fl[i], rd[i], unk[i], to[i], pc[i]} !== exp_v) begin
                    errors++;
                    $display("FAIL random n=%0d inst%0d got %h want %h (rst=%b req=%b exc=%h)",
                             n, i, {st[i], fl[i], rd[i], unk[i], to[i], pc[i]}, exp_v, rst, req, exc);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_stall_merge();
        test_exception_decode();
        test_simultaneous();
        test_watchdog();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
